// File: rtl/addsub_pipe16.sv
// Two-stage pipelined 16-bit add/subtract with valid/ready handshakes, built on the lac4 lookahead carry unit.
// Optional sticky overflow flag: define STICKY_OVF_EN to add ovf_sticky/ovf_clr.

// 16-bit two-level carry lookahead: four 4-bit groups, then a lookahead across the groups.
module lac4 (
  output logic [15:0] c,
  output logic        gout,
  output logic        pout,
  input  logic        Cin,
  input  logic [15:0] g,
  input  logic [15:0] p
);

  logic [3:0] gg;
  logic [3:0] gp;
  logic [3:0] cg;

  always_comb begin
    gg = '0;
    gp = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
  end

  always_comb begin
    cg[0] = Cin;
    cg[1] = gg[0] | (gp[0] & Cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & Cin);
    gout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]);
    pout  = &gp;
  end

  // c[i] is the carry into bit i, expanded from the group carry-in
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
  end

endmodule

module addsub_pipe16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
`ifdef STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             neg
);

  generate
    if (WIDTH != 16) begin : g_width_check
      $error("addsub_pipe16: WIDTH must be 16 to match lac4");
    end
  endgenerate

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_r;
  logic [WIDTH-1:0] p_r;
  logic             cin_r;
  logic             s1_valid;
  logic             s2_load;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] c;
  logic             gout;
  logic             pout;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid & s2_load;

  assign bx   = sub ? ~b : b;
  assign g_in = a & bx;
  assign p_in = a ^ bx;

  always_ff @(posedge clk) begin
    if (reset) begin
      g_r      <= '0;
      p_r      <= '0;
      cin_r    <= 1'b0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      g_r      <= g_in;
      p_r      <= p_in;
      cin_r    <= sub;
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  lac4 u_lac4 (
    .c    (c),
    .gout (gout),
    .pout (pout),
    .Cin  (cin_r),
    .g    (g_r),
    .p    (p_r)
  );

  assign sum_next  = p_r ^ c;
  assign cout_next = gout | (pout & cin_r);

  // Result registers only change on a load, so they hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      sum       <= sum_next;
      cout      <= cout_next;
      ovf       <= c[WIDTH-1] ^ cout_next;
      zero      <= (sum_next == '0);
      neg       <= sum_next[WIDTH-1];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STICKY_OVF_EN
  // Setting takes priority so an overflow is never lost to a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid & out_ready & ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_pipe16.sv
// Directed self-checking bench for addsub_pipe16; define STICKY_OVF_EN to also exercise the sticky overflow flag.
module tb_addsub_pipe16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;
`ifdef STICKY_OVF_EN
  logic        ovf_clr;
  logic        ovf_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_pipe16 #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
`ifdef STICKY_OVF_EN
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
`endif
    .neg        (neg)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] av,
                               input logic [15:0] bv, input logic s);
    in_valid = v;
    a        = av;
    b        = bv;
    sub      = s;
  endtask

  // Flags packed as {cout, ovf, zero, neg}
  task automatic sendOne(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input logic [15:0] expSum, input logic [3:0] expFlags);
    applyStimulus(1'b1, av, bv, s);
    stepClk();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput({tag, "_lat1_valid"}, out_valid, 0);
    stepClk();
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_flags"}, {cout, ovf, zero, neg}, expFlags);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    stepClk();
    stepClk();
    reset = 1'b0;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_sum", sum, 16'h0000);
    checkOutput("rst_flags", {cout, ovf, zero, neg}, 4'b0000);
    checkOutput("rst_in_ready", in_ready, 1);

    sendOne("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
    sendOne("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010);
    sendOne("sub_5_5",    16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b1010);
    sendOne("sub_3_5",    16'h0003, 16'h0005, 1'b1, 16'hFFFE, 4'b0001);
    sendOne("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b1100);
    sendOne("add_1234",   16'h1234, 16'h4321, 1'b0, 16'h5555, 4'b0000);
    stepClk();
    checkOutput("drain_valid", out_valid, 0);

    // Back-to-back stream: beat t-1 appears right after edge t
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        applyStimulus(1'b1, 16'(t), 16'(t), 1'b0);
        checkOutput($sformatf("stream_in_ready_%0d", t), in_ready, 1);
      end else begin
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      end
      stepClk();
      if (t >= 1 && t <= 8) begin
        checkOutput($sformatf("stream_valid_%0d", t - 1), out_valid, 1);
        checkOutput($sformatf("stream_sum_%0d", t - 1), sum, 32'(2 * (t - 1)));
      end
    end
    checkOutput("stream_end_valid", out_valid, 0);

    // Backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1000, 16'h0001, 1'b0);
    checkOutput("bp_ready0", in_ready, 1);
    stepClk();
    applyStimulus(1'b1, 16'h2000, 16'h0002, 1'b0);
    checkOutput("bp_ready1", in_ready, 1);
    stepClk();
    applyStimulus(1'b1, 16'h3000, 16'h0003, 1'b0);
    checkOutput("bp_ready2", in_ready, 0);
    checkOutput("bp_valid", out_valid, 1);
    checkOutput("bp_sum0", sum, 16'h1001);
    stepClk();
    checkOutput("bp_hold_ready", in_ready, 0);
    checkOutput("bp_hold_sum", sum, 16'h1001);
    stepClk();
    checkOutput("bp_hold2_sum", sum, 16'h1001);
    checkOutput("bp_hold2_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", in_ready, 1);
    stepClk();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("bp_out1_valid", out_valid, 1);
    checkOutput("bp_out1_sum", sum, 16'h2002);
    stepClk();
    checkOutput("bp_out2_valid", out_valid, 1);
    checkOutput("bp_out2_sum", sum, 16'h3003);
    stepClk();
    checkOutput("bp_empty", out_valid, 0);

    // Reset with two beats in flight, and a beat offered during reset
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0101, 16'h0101, 1'b0);
    stepClk();
    applyStimulus(1'b1, 16'h0202, 16'h0202, 1'b0);
    stepClk();
    checkOutput("prerst_valid", out_valid, 1);
    applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 1'b0);
    reset = 1'b1;
    stepClk();
    reset = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    out_ready = 1'b1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_sum", sum, 16'h0000);
    checkOutput("midrst_flags", {cout, ovf, zero, neg}, 4'b0000);
    checkOutput("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput($sformatf("postrst_stale_%0d", i), out_valid, 0);
    end

`ifdef STICKY_OVF_EN
    checkOutput("sticky_rst", ovf_sticky, 0);
    sendOne("st_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
    sendOne("st_clean0", 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    checkOutput("sticky_set", ovf_sticky, 1);
    sendOne("st_clean1", 16'h0002, 16'h0002, 1'b0, 16'h0004, 4'b0000);
    sendOne("st_clean2", 16'h0003, 16'h0003, 1'b0, 16'h0006, 4'b0000);
    stepClk();
    checkOutput("sticky_kept", ovf_sticky, 1);
    ovf_clr = 1'b1;
    stepClk();
    ovf_clr = 1'b0;
    checkOutput("sticky_clr", ovf_sticky, 0);
    sendOne("st_ovf2", 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 4'b0101);
    ovf_clr = 1'b1;
    stepClk();
    ovf_clr = 1'b0;
    checkOutput("sticky_set_wins", ovf_sticky, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
